// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Sequences fetch/decode/execute/memory/writeback and drives all datapath selects and enables.
module multicycle_main_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             regdst,
  output logic             memtoreg,
  output logic             illegal_op,
  output logic [3:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state, next;
  logic   ready;
  logic   pcwrite, branch, retire;
  logic   irwrite_d, memwrite_d, regwrite_d;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      illegal_op  <= 1'b0;
      dbg_retired <= '0;
    end else begin
      state <= next;
      if (next == TRAP)
        illegal_op <= 1'b1;
      if (retire)
        dbg_retired <= dbg_retired + CNT_W'(1);
    end
  end

  always_comb begin
    next       = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    irwrite_d  = 1'b0;
    memwrite_d = 1'b0;
    regwrite_d = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_d = ready;
        pcwrite   = ready;
        if (ready) next = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYP:      next = RTYPEEX;
          OP_BEQ:       next = BEQEX;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JEX;
          default:      next = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (ready) next = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
        retire     = 1'b1;
        next       = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_d = 1'b1;
        if (ready) begin
          retire = 1'b1;
          next   = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        next    = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
        retire     = 1'b1;
        next       = FETCH;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
        next    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = ADDIWB;
      end
      ADDIWB: begin
        regwrite_d = 1'b1;
        retire     = 1'b1;
        next       = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
        next    = FETCH;
      end
      TRAP: next = TRAP;
      default: next = FETCH;
    endcase
  end

  // Reset is asynchronous, so the ready-dependent FETCH enables must be masked by reset itself.
  assign pcen      = ~reset & (pcwrite | (branch & zero));
  assign irwrite   = ~reset & irwrite_d;
  assign memwrite  = ~reset & memwrite_d;
  assign regwrite  = ~reset & regwrite_d;
  assign dbg_state = state;

endmodule
